mips_run_ctrl: RTL and testbench
================================

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of the monitored program counter.
REQ-002 Parameter DATA_WIDTH, default 16, width of the monitored ALU result.
REQ-003 Parameter RST_CYCLES, default 5, number of cycles core_reset is held before a run.
REQ-004 Parameter STALL_LIMIT, default 4, number of consecutive unchanged-PC cycles that counts as a halt.
REQ-005 Parameter TIMEOUT, default 1024, maximum number of RUN cycles before the run is aborted.
REQ-006 Parameter CNT_WIDTH, default 16, width of cycle_count.
REQ-007 clk  in  1  single clock; all logic is rising-edge.
REQ-008 reset  in  1  synchronous, active-high block reset.
REQ-009 start  in  1  one-cycle request to begin a run.
REQ-010 pc_in  in  PC_WIDTH  core pc_out.
REQ-011 alu_in  in  DATA_WIDTH  core alu_result.
REQ-012 core_reset  out  1  drives the core's reset.
REQ-013 running  out  1  high while in RUN.
REQ-014 done  out  1  halt detected; sticky.
REQ-015 timed_out  out  1  TIMEOUT expired; sticky.
REQ-016 cycle_count  out  CNT_WIDTH  RUN cycles elapsed.
REQ-017 final_pc  out  PC_WIDTH  PC captured at halt or timeout.
REQ-018 last_alu  out  DATA_WIDTH  alu_in sampled on the last RUN cycle.

Function
REQ-019 FSM states SHALL be IDLE, HOLD, RUN, DONE, ABORT; all outputs SHALL be registered.
REQ-020 IDLE: core_reset=1; start=1 moves to HOLD and loads the hold counter with RST_CYCLES.
REQ-021 HOLD: core_reset=1 for exactly RST_CYCLES cycles, then RUN; cycle_count, stall counter, done, timed_out and final_pc clear on HOLD entry.
REQ-022 RUN: core_reset=0, running=1, and cycle_count increments by 1 per cycle, saturating at all-ones.
REQ-023 RUN: a prev_pc register is updated every cycle; pc_in==prev_pc increments the stall counter, otherwise it clears to 0; the first RUN cycle never counts as a stall.
REQ-024 When the stall counter reaches STALL_LIMIT, the FSM SHALL move to DONE, set done=1 and capture final_pc=pc_in.
REQ-025 When cycle_count reaches TIMEOUT-1 in RUN without a halt, the FSM SHALL move to ABORT, set timed_out=1 and capture final_pc=pc_in.
REQ-026 If halt and timeout conditions occur in the same cycle, halt SHALL win (DONE, timed_out stays 0).
REQ-027 last_alu SHALL load alu_in on every RUN cycle and hold in all other states.
REQ-028 DONE/ABORT: core_reset=1 and running=0; status outputs and counters hold; start=1 moves to HOLD (rerun).
REQ-029 start SHALL be ignored in HOLD and RUN.
REQ-030 STALL_LIMIT>=1, RST_CYCLES>=1 and TIMEOUT<=2**CNT_WIDTH are legal-parameter preconditions.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, core_reset=1, running=0, done=0, timed_out=0, and cycle_count, final_pc and last_alu to 0, from any state including mid-RUN.
REQ-032 reset SHALL have priority over start in the same cycle.

Structure
REQ-033 State encoding and default parameter constants SHALL live in the shared package mips16_pkg.
REQ-034 The halt detector (prev_pc plus stall counter) SHALL be one sub-module, mips_halt_det; the FSM and counters remain in mips_run_ctrl.

Verification
REQ-035 Hold count: start at cycle 0 -> core_reset high for exactly 5 cycles after the HOLD entry, then low with running=1.
REQ-036 Halt: pc_in steps 0,2,4,6 then holds 6 -> done=1 after the 4th repeated cycle, final_pc=6, timed_out=0.
REQ-037 Timeout with TIMEOUT=16 and an ever-changing pc_in -> timed_out=1, cycle_count=15, core_reset=1.
REQ-038 Tie: stall limit and TIMEOUT-1 reached on the same cycle -> done=1, timed_out=0.
REQ-039 Reset mid-RUN at cycle_count=7 -> next cycle is IDLE with every output at its reset value; start then reruns normally.
REQ-040 Rerun from DONE with start -> counters and flags clear on HOLD entry; last_alu holds until the first RUN cycle.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared types and default constants for the MIPS16 run controller.
// Holds the run-FSM state encoding and parameter defaults.
package mips16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } run_state_t;

    localparam int DEF_PC_WIDTH    = 16;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_RST_CYCLES  = 5;
    localparam int DEF_STALL_LIMIT = 4;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_CNT_WIDTH   = 16;

endpackage

// File: rtl/mips_halt_det.sv
// Halt detector: flags a halt once the PC has stayed unchanged
// for STALL_LIMIT consecutive enabled cycles.
// Ports: clk, reset (sync, active-high), clr (restart detection),
//        en (core running), pc_in (core PC), halt (combinational).
module mips_halt_det
    import mips16_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic                halt
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

    logic [PC_WIDTH-1:0] prev_pc;
    logic                primed;
    logic [SW-1:0]       stall_cnt;
    logic [SW-1:0]       stall_nxt;

    // The first enabled cycle has no valid prev_pc, so it never stalls.
    always_comb begin
        stall_nxt = '0;
        if (primed && (pc_in == prev_pc)) begin
            if (stall_cnt == LIMIT)
                stall_nxt = stall_cnt;
            else
                stall_nxt = stall_cnt + SW'(1);
        end
    end

    assign halt = en && (stall_nxt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            prev_pc   <= '0;
            primed    <= 1'b0;
            stall_cnt <= '0;
        end else if (en) begin
            prev_pc   <= pc_in;
            primed    <= 1'b1;
            stall_cnt <= stall_nxt;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: holds the core in reset, lets it run, and stops it
// on a PC halt or a cycle timeout, keeping sticky status.
// Ports: clk, reset (sync, active-high), start, pc_in, alu_in;
//        core_reset, running, done, timed_out, cycle_count,
//        final_pc, last_alu (all registered).
module mips_run_ctrl
    import mips16_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   pc_in,
    input  logic [DATA_WIDTH-1:0] alu_in,
    output logic                  core_reset,
    output logic                  running,
    output logic                  done,
    output logic                  timed_out,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [PC_WIDTH-1:0]   final_pc,
    output logic [DATA_WIDTH-1:0] last_alu
);

    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);

    run_state_t           state;
    logic [HW-1:0]        hold_cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 hold_entry;
    logic                 in_run;
    logic                 halt;

    assign in_run     = (state == ST_RUN);
    assign hold_entry = start && (state == ST_IDLE ||
                                  state == ST_DONE ||
                                  state == ST_ABORT);

    // Saturating run-cycle counter.
    assign cnt_nxt = (&cycle_count) ? cycle_count
                                    : cycle_count + CNT_WIDTH'(1);

    mips_halt_det #(
        .PC_WIDTH    (PC_WIDTH),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_halt_det (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_entry),
        .en    (in_run),
        .pc_in (pc_in),
        .halt  (halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            final_pc    <= '0;
            last_alu    <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_ABORT: begin
                    if (start) begin
                        state       <= ST_HOLD;
                        hold_cnt    <= HW'(RST_CYCLES);
                        done        <= 1'b0;
                        timed_out   <= 1'b0;
                        cycle_count <= '0;
                        final_pc    <= '0;
                    end
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt - HW'(1);
                    if (hold_cnt == HW'(1)) begin
                        state      <= ST_RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_count <= cnt_nxt;
                    last_alu    <= alu_in;
                    // Halt is checked first so it wins a tie.
                    if (halt) begin
                        state      <= ST_DONE;
                        done       <= 1'b1;
                        final_pc   <= pc_in;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                    end else if (cnt_nxt >= TO_LAST) begin
                        state      <= ST_ABORT;
                        timed_out  <= 1'b1;
                        final_pc   <= pc_in;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl.
// Random and directed runs checked against a windowed halt model.
module tb_mips_run_ctrl;

    localparam int RST_CYCLES  = 5;
    localparam int STALL_LIMIT = 4;
    localparam int TIMEOUT     = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pc_in;
    logic [15:0] alu_in;
    logic        core_reset;
    logic        running;
    logic        done;
    logic        timed_out;
    logic [15:0] cycle_count;
    logic [15:0] final_pc;
    logic [15:0] last_alu;

    logic [15:0] pcs  [32];
    logic [15:0] alus [32];
    int          nrun;
    int          checks = 0;
    int          passes = 0;

    mips_run_ctrl #(
        .PC_WIDTH    (16),
        .DATA_WIDTH  (16),
        .RST_CYCLES  (RST_CYCLES),
        .STALL_LIMIT (STALL_LIMIT),
        .TIMEOUT     (TIMEOUT),
        .CNT_WIDTH   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_in       (pc_in),
        .alu_in      (alu_in),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count),
        .final_pc    (final_pc),
        .last_alu    (last_alu)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A run halts at the first index whose PC equals each of the
    // STALL_LIMIT PCs before it; otherwise it lasts TIMEOUT-1 cycles.
    function automatic void model_run(output int n, output bit halted,
                                      output logic [15:0] fpc);
        n      = TIMEOUT - 1;
        halted = 1'b0;
        fpc    = pcs[TIMEOUT-2];
        for (int i = STALL_LIMIT; i < TIMEOUT - 1; i++) begin
            bit same = 1'b1;
            for (int k = 1; k <= STALL_LIMIT; k++)
                if (pcs[i-k] !== pcs[i]) same = 1'b0;
            if (same) begin
                n      = i + 1;
                halted = 1'b1;
                fpc    = pcs[i];
                return;
            end
        end
    endfunction

    task automatic do_run(input bit do_start, input bit poke,
                          input int maxc);
        int w = 0;
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        while (running !== 1'b1 && w < 20) begin
            if (poke) start = 1'($urandom);
            tick();
            w++;
        end
        start = 1'b0;
        checks++;
        if (running !== 1'b1)
            $display("FAIL run_entry: running=%b want 1", running);
        else
            passes++;
        nrun = 0;
        while (running === 1'b1 && nrun < maxc) begin
            pc_in  = pcs[nrun];
            alu_in = alus[nrun];
            if (poke) start = 1'($urandom);
            tick();
            nrun++;
        end
        start = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 32; i++) begin
            pcs[i]  = (i < 4) ? 16'(2 * i) : 16'd6;
            alus[i] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        pc_in = '0;
        alu_in = '0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (core_reset !== 1'b1)
            $display("FAIL rst_core_reset: got %b want 1", core_reset);
        else passes++;
        checks++;
        if (running !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0)
            $display("FAIL rst_flags: got %b%b%b want 000",
                     running, done, timed_out);
        else passes++;
        checks++;
        if (cycle_count !== 16'd0 || final_pc !== 16'd0 ||
            last_alu !== 16'd0)
            $display("FAIL rst_regs: got %h %h %h want 0 0 0",
                     cycle_count, final_pc, last_alu);
        else passes++;
        // reset beats start in the same cycle
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        repeat (RST_CYCLES + 2) tick();
        checks++;
        if (core_reset !== 1'b1 || running !== 1'b0)
            $display("FAIL rst_prio: core_reset=%b running=%b want 1 0",
                     core_reset, running);
        else passes++;
    endtask

    task automatic test_hold_halt();
        int n;
        bit h;
        logic [15:0] f;
        fill_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= RST_CYCLES; k++) begin
            tick();
            checks++;
            if (k < RST_CYCLES) begin
                if (core_reset !== 1'b1 || running !== 1'b0)
                    $display("FAIL hold_%0d: core_reset=%b running=%b want 1 0",
                             k, core_reset, running);
                else passes++;
            end else begin
                if (core_reset !== 1'b0 || running !== 1'b1)
                    $display("FAIL hold_end: core_reset=%b running=%b want 0 1",
                             core_reset, running);
                else passes++;
            end
        end
        do_run(1'b0, 1'b0, 32);
        model_run(n, h, f);
        checks++;
        if (nrun !== 8 || n !== 8)
            $display("FAIL halt_len: got %0d model %0d want 8", nrun, n);
        else passes++;
        checks++;
        if (done !== 1'b1 || timed_out !== 1'b0)
            $display("FAIL halt_flags: done=%b timed_out=%b want 1 0",
                     done, timed_out);
        else passes++;
        checks++;
        if (final_pc !== 16'd6 || cycle_count !== 16'd8)
            $display("FAIL halt_regs: pc=%0d cnt=%0d want 6 8",
                     final_pc, cycle_count);
        else passes++;
        checks++;
        if (last_alu !== alus[7] || core_reset !== 1'b1)
            $display("FAIL halt_alu: alu=%h core_reset=%b want %h 1",
                     last_alu, core_reset, alus[7]);
        else passes++;
        repeat (3) tick();
        checks++;
        if (done !== 1'b1 || cycle_count !== 16'd8 || running !== 1'b0)
            $display("FAIL halt_sticky: done=%b cnt=%0d run=%b want 1 8 0",
                     done, cycle_count, running);
        else passes++;
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 32; i++) begin
            pcs[i]  = 16'(4 * i + 1);
            alus[i] = 16'($urandom);
        end
        do_run(1'b1, 1'b0, 32);
        checks++;
        if (timed_out !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1)
            $display("FAIL to_flags: to=%b done=%b cr=%b want 1 0 1",
                     timed_out, done, core_reset);
        else passes++;
        checks++;
        if (cycle_count !== 16'(TIMEOUT - 1) || nrun !== TIMEOUT - 1)
            $display("FAIL to_count: cnt=%0d runs=%0d want %0d",
                     cycle_count, nrun, TIMEOUT - 1);
        else passes++;
        checks++;
        if (final_pc !== pcs[TIMEOUT-2] || last_alu !== alus[TIMEOUT-2])
            $display("FAIL to_regs: pc=%h alu=%h want %h %h", final_pc,
                     last_alu, pcs[TIMEOUT-2], alus[TIMEOUT-2]);
        else passes++;
    endtask

    task automatic test_tie();
        for (int i = 0; i < 32; i++) begin
            pcs[i]  = (i < 11) ? 16'(i) : 16'd10;
            alus[i] = 16'($urandom);
        end
        do_run(1'b1, 1'b0, 32);
        checks++;
        if (done !== 1'b1 || timed_out !== 1'b0)
            $display("FAIL tie_flags: done=%b to=%b want 1 0",
                     done, timed_out);
        else passes++;
        checks++;
        if (cycle_count !== 16'(TIMEOUT - 1) || final_pc !== 16'd10)
            $display("FAIL tie_regs: cnt=%0d pc=%0d want %0d 10",
                     cycle_count, final_pc, TIMEOUT - 1);
        else passes++;
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 32; i++) begin
            pcs[i]  = 16'(3 * i);
            alus[i] = 16'($urandom);
        end
        do_run(1'b1, 1'b0, 7);
        checks++;
        if (cycle_count !== 16'd7 || running !== 1'b1)
            $display("FAIL mid_count: cnt=%0d run=%b want 7 1",
                     cycle_count, running);
        else passes++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 ||
            timed_out !== 1'b0)
            $display("FAIL mid_flags: cr=%b run=%b done=%b to=%b want 1000",
                     core_reset, running, done, timed_out);
        else passes++;
        checks++;
        if (cycle_count !== 16'd0 || final_pc !== 16'd0 ||
            last_alu !== 16'd0)
            $display("FAIL mid_regs: %h %h %h want 0 0 0",
                     cycle_count, final_pc, last_alu);
        else passes++;
        fill_halt();
        do_run(1'b1, 1'b0, 32);
        checks++;
        if (done !== 1'b1 || final_pc !== 16'd6 || cycle_count !== 16'd8)
            $display("FAIL mid_rerun: done=%b pc=%0d cnt=%0d want 1 6 8",
                     done, final_pc, cycle_count);
        else passes++;
    endtask

    task automatic test_rerun();
        logic [15:0] held;
        held = last_alu;
        for (int i = 0; i < 32; i++) begin
            pcs[i]  = 16'(i + 100);
            alus[i] = 16'($urandom);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || timed_out !== 1'b0 || cycle_count !== 16'd0 ||
            final_pc !== 16'd0)
            $display("FAIL rerun_clear: done=%b to=%b cnt=%0d pc=%0d want 0",
                     done, timed_out, cycle_count, final_pc);
        else passes++;
        tick();
        checks++;
        if (last_alu !== held || core_reset !== 1'b1)
            $display("FAIL rerun_hold_alu: alu=%h cr=%b want %h 1",
                     last_alu, core_reset, held);
        else passes++;
        do_run(1'b0, 1'b0, 1);
        checks++;
        if (last_alu !== alus[0])
            $display("FAIL rerun_first_alu: got %h want %h",
                     last_alu, alus[0]);
        else passes++;
        do_run(1'b0, 1'b0, 32);
        checks++;
        if (timed_out !== 1'b1 || cycle_count !== 16'(TIMEOUT - 1))
            $display("FAIL rerun_end: to=%b cnt=%0d want 1 %0d",
                     timed_out, cycle_count, TIMEOUT - 1);
        else passes++;
    endtask

    task automatic test_random();
        int n;
        bit h;
        logic [15:0] f;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 32; i++) begin
                if (i > 0 && $urandom_range(0, 99) < 65)
                    pcs[i] = pcs[i-1];
                else
                    pcs[i] = 16'($urandom_range(0, 7));
                alus[i] = 16'($urandom);
            end
            model_run(n, h, f);
            do_run(1'b1, 1'b1, 32);
            checks++;
            if (nrun !== n || cycle_count !== 16'(n))
                $display("FAIL rand%0d_len: runs=%0d cnt=%0d want %0d",
                         r, nrun, cycle_count, n);
            else passes++;
            checks++;
            if (done !== h || timed_out !== !h)
                $display("FAIL rand%0d_flags: done=%b to=%b want %b %b",
                         r, done, timed_out, h, !h);
            else passes++;
            checks++;
            if (final_pc !== f || last_alu !== alus[n-1])
                $display("FAIL rand%0d_regs: pc=%h alu=%h want %h %h",
                         r, final_pc, last_alu, f, alus[n-1]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_hold_halt();
        test_timeout();
        test_tie();
        test_reset_mid_run();
        test_rerun();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
